i2s_audio_tx: RTL and testbench

Serial audio transmitter that drives the on-board I2S stereo DAC (Pmod I2S class) from the parallel 16-bit `audio_left` / `audio_right` samples produced by the buzzer/tone generators. It generates the DAC master clock, bit clock and word-select clock from the system clock with a single free-running counter. Once per frame it latches both channel samples into a shift register and serialises them MSB-first in standard I2S format. It sits between the tone/volume logic and the top-level DAC pins.

---
 rtl/i2s_audio_tx_if.sv | 24 ++
 rtl/i2s_audio_tx.sv | 63 ++++++
 tb/tb_i2s_audio_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/i2s_audio_tx_if.sv
// Sample/control bundle between the tone logic and the I2S transmitter, plus the DAC pins.
// The master side supplies samples and mute; the slave side (the transmitter) drives the DAC pins.
interface i2s_audio_tx_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] audio_left;
    logic [DATA_W-1:0] audio_right;
    logic              mute;
    logic              audio_mclk;
    logic              audio_sck;
    logic              audio_lrck;
    logic              audio_sdin;
    logic              sample_tick;

    modport master (
        output audio_left, audio_right, mute,
        input  audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_tick
    );

    modport slave (
        input  audio_left, audio_right, mute,
        output audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_tick
    );
endinterface

// File: rtl/i2s_audio_tx.sv
// Standard-I2S stereo transmitter: one 9-bit counter yields mclk/sck/lrck, and a 32-bit shifter sends L then R MSB-first.
// Optional macro I2S_AUDIO_TX_MONO_EN duplicates the left sample into both slots.
module i2s_audio_tx #(
    parameter int DATA_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    i2s_audio_tx_if.slave bus
);
    localparam int FRAME_W = 2 * DATA_W;

    logic [8:0]         cnt_q, cnt_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] latch_word;
    logic               sdin_q, sdin_d;
    logic               tick_q, tick_d;
    logic               latch_edge;
    logic               shift_edge;

    assign latch_edge = (cnt_q == 9'd15);
    assign shift_edge = (cnt_q[3:0] == 4'hF) && !latch_edge;

`ifdef I2S_AUDIO_TX_MONO_EN
    assign latch_word = bus.mute ? '0 : {bus.audio_left, bus.audio_left};
`else
    assign latch_word = bus.mute ? '0 : {bus.audio_left, bus.audio_right};
`endif

    // Latch at the end of slot 0 so the MSB lands one sck after the lrck edge.
    always_comb begin
        cnt_d   = cnt_q + 9'd1;
        shift_d = shift_q;
        sdin_d  = sdin_q;
        tick_d  = latch_edge;
        if (latch_edge) begin
            shift_d = latch_word;
            sdin_d  = latch_word[FRAME_W-1];
        end else if (shift_edge) begin
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            sdin_d  = shift_q[FRAME_W-2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
            sdin_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            sdin_q  <= sdin_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.audio_mclk  = cnt_q[1];
    assign bus.audio_sck   = cnt_q[3];
    assign bus.audio_lrck  = cnt_q[8];
    assign bus.audio_sdin  = sdin_q;
    assign bus.sample_tick = tick_q;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: clock-ratio checks, directed frames, random frames and a mid-frame reset.
// The model works from the rising-edge count since reset release: cnt = n mod 512, latch at n mod 512 == 16.
module tb_i2s_audio_tx;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    logic [31:0] expWord = '0;

    always #5 clk = ~clk;

    i2s_audio_tx_if #(.DATA_W(16)) bus();

    i2s_audio_tx #(.DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic stepCycle();
        @(posedge clk);
        if (rst_n) cyc++;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    endtask

    function automatic logic [31:0] modelWord(input logic [15:0] l, input logic [15:0] r, input logic m);
        if (m) return 32'h0;
`ifdef I2S_AUDIO_TX_MONO_EN
        return {l, l};
`else
        return {l, r};
`endif
    endfunction

    task automatic driveInputs(input logic [15:0] l, input logic [15:0] r, input logic m);
        bus.audio_left  = l;
        bus.audio_right = r;
        bus.mute        = m;
    endtask

    // Drive the pair just before a latch edge, clock through it and record the expected word.
    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input logic m);
        while (cyc % 512 != 15) stepCycle();
        driveInputs(l, r, m);
        stepCycle();
        expWord = modelWord(l, r, m);
        checkOutput("sample_tick_at_latch", {31'b0, bus.sample_tick}, 32'h1);
    endtask

    // Slot k (1..32 after the latch) must carry word bit 32-k for the whole slot.
    task automatic checkFrame(input string tag, input int chgCnt,
                              input logic [15:0] nl, input logic [15:0] nr, input logic nm);
        int base;
        int offs[3];
        base = cyc - 16;
        offs = '{1, 8, 15};
        for (int k = 1; k <= 32; k++) begin
            for (int p = 0; p < 3; p++) begin
                while (cyc < base + 16 * k + offs[p]) begin
                    stepCycle();
                    if (chgCnt >= 0 && cyc == base + chgCnt) driveInputs(nl, nr, nm);
                end
                checkOutput(tag, {31'b0, bus.audio_sdin}, {31'b0, expWord[32-k]});
                if (offs[p] == 8) checkOutput("sck_high_mid_slot", {31'b0, bus.audio_sck}, 32'h1);
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mclk"}, {31'b0, bus.audio_mclk}, 32'h0);
        checkOutput({tag, "_sck"},  {31'b0, bus.audio_sck},  32'h0);
        checkOutput({tag, "_lrck"}, {31'b0, bus.audio_lrck}, 32'h0);
        checkOutput({tag, "_sdin"}, {31'b0, bus.audio_sdin}, 32'h0);
        checkOutput({tag, "_tick"}, {31'b0, bus.sample_tick}, 32'h0);
    endtask

    initial begin
        logic [15:0] rl, rr, nl, nr;
        logic        rm;

        driveInputs(16'h0, 16'h0, 1'b0);
        rst_n = 1'b0;
        repeat (5) stepCycle();
        checkAllZero("reset");

        rst_n = 1'b1;
        cyc   = 0;
        for (int n = 1; n <= 1100; n++) begin
            stepCycle();
            checkOutput("mclk", {31'b0, bus.audio_mclk}, (n >> 1) & 1);
            checkOutput("sck",  {31'b0, bus.audio_sck},  (n >> 3) & 1);
            checkOutput("lrck", {31'b0, bus.audio_lrck}, (n >> 8) & 1);
            checkOutput("tick", {31'b0, bus.sample_tick}, {31'b0, (n % 512) == 16});
        end

        $display("[TB] stereo frame");
        applyStimulus(16'hA5F0, 16'h0F0F, 1'b0);
        checkFrame("stereo_bit", -1, 16'hA5F0, 16'h0F0F, 1'b0);

        $display("[TB] mute");
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
        checkFrame("mute_bit", 200, 16'hFFFF, 16'hFFFF, 1'b0);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
        checkFrame("unmute_bit", -1, 16'hFFFF, 16'hFFFF, 1'b0);

        $display("[TB] sample hold");
        applyStimulus(16'h8000, 16'h1234, 1'b0);
        checkFrame("hold_cur_bit", 17, 16'h0001, 16'h1234, 1'b0);
        applyStimulus(16'h0001, 16'h1234, 1'b0);
        checkFrame("hold_next_bit", -1, 16'h0001, 16'h1234, 1'b0);

        applyStimulus(16'h1234, 16'hFFFF, 1'b0);
        checkFrame("mono_cfg_bit", -1, 16'h1234, 16'hFFFF, 1'b0);

        $display("[TB] random frames");
        for (int f = 0; f < 5; f++) begin
            rl = 16'($urandom);
            rr = 16'($urandom);
            rm = ($urandom_range(0, 3) == 0);
            nl = 16'($urandom);
            nr = 16'($urandom);
            applyStimulus(rl, rr, rm);
            checkFrame("random_bit", int'($urandom_range(20, 500)), nl, nr, 1'($urandom));
        end

        $display("[TB] mid-frame reset");
        while (cyc % 512 != 328) stepCycle();
        checkOutput("lrck_before_reset", {31'b0, bus.audio_lrck}, 32'h1);
        #2 rst_n = 1'b0;
        #1 checkAllZero("async_reset");
        rl = 16'($urandom);
        rr = 16'($urandom);
        driveInputs(rl, rr, 1'b0);
        @(negedge clk);
        repeat (3) stepCycle();
        rst_n = 1'b1;
        cyc   = 0;
        for (int n = 1; n <= 16; n++) begin
            stepCycle();
            checkOutput("restart_tick", {31'b0, bus.sample_tick}, {31'b0, n == 16});
            checkOutput("restart_lrck", {31'b0, bus.audio_lrck}, 32'h0);
        end
        expWord = modelWord(rl, rr, 1'b0);
        checkFrame("restart_bit", -1, rl, rr, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
